// File: rtl/fwft_fifo_packer.sv
// Drains a first-word-fall-through FIFO and packs NWORDS narrow words into one wide
// valid/ready beat; partial beats leave on idle timeout or flush with a keep mask.
module fwft_fifo_packer #(
    parameter int DWIDTH  = 8,
    parameter int NWORDS  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [DWIDTH-1:0]          fifo_data,
    output logic                       fifo_read,
    input  logic                       flush,
    output logic [DWIDTH*NWORDS-1:0]   m_data,
    output logic [NWORDS-1:0]          m_keep,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       busy
);

    localparam int CWIDTH = $clog2(NWORDS + 1);
    localparam int TWIDTH = $clog2(TIMEOUT);
    localparam int WWIDTH = DWIDTH * NWORDS;

    logic [WWIDTH-1:0] acc;
    logic [CWIDTH-1:0] count;
    logic [TWIDTH-1:0] idle;
    logic              pending;
    logic [WWIDTH-1:0] out_data;
    logic [NWORDS-1:0] out_keep;
    logic              out_valid;

    logic              rd;
    logic              slot_free;
    logic              fire;
    logic [CWIDTH-1:0] post_count;
    logic [WWIDTH-1:0] acc_next;
    logic [NWORDS-1:0] keep_next;

    // A pending emit freezes the accumulator, so reads must stop until it drains.
    assign rd         = !rst && !fifo_empty && !pending;
    assign fifo_read  = rd;
    assign slot_free  = !out_valid || m_ready;
    assign post_count = count + {{(CWIDTH-1){1'b0}}, rd};

    assign fire = pending
               || (post_count == CWIDTH'(NWORDS))
               || (flush && (post_count != '0))
               || ((idle == TWIDTH'(TIMEOUT - 1)) && (post_count != '0) && !rd);

    always_comb begin
        acc_next  = acc;
        keep_next = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (rd && (count == CWIDTH'(i))) begin
                acc_next[i*DWIDTH +: DWIDTH] = fifo_data;
            end
            keep_next[i] = (CWIDTH'(i) < post_count);
        end
    end

    // The accumulator is zeroed on every emit so unused slots of a partial beat read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            idle      <= '0;
            pending   <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && m_ready) begin
                out_valid <= 1'b0;
            end
            if (fire && slot_free) begin
                out_data  <= acc_next;
                out_keep  <= keep_next;
                out_valid <= 1'b1;
                acc       <= '0;
                count     <= '0;
                idle      <= '0;
                pending   <= 1'b0;
            end else begin
                acc     <= acc_next;
                count   <= post_count;
                pending <= fire;
                if (rd || (post_count == '0)) begin
                    idle <= '0;
                end else if (idle != TWIDTH'(TIMEOUT - 1)) begin
                    idle <= idle + 1'b1;
                end
            end
        end
    end

    assign m_data  = out_data;
    assign m_keep  = out_keep;
    assign m_valid = out_valid;
    assign busy    = (count != '0) || out_valid;

endmodule

// File: doc/fwft_fifo_packer.md
Name: fwft_fifo_packer

Overview:
- Consumer (read side) of a first-word-fall-through FIFO: drains DWIDTH-bit words and packs NWORDS of them into one wide word.
- Presents the packed word on a valid/ready output stream.
- Partial words are emitted on idle timeout or explicit flush, with a per-word keep mask.
- Sits between a mini FWFT FIFO (empty/read/data_out) and a wide readout or DMA path.

Parameters:
- DWIDTH, 8, width of one FIFO word
- NWORDS, 4, FIFO words per packed output word (>=2)
- TIMEOUT, 16, idle cycles with a partial accumulator before forced emit (>=2)
- CWIDTH, $clog2(NWORDS+1), word-count width (derived, not overridden)
- TWIDTH, $clog2(TIMEOUT), idle-counter width (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DWIDTH  FIFO head word (valid while fifo_empty=0)
- fifo_read  out  1  pop strobe; head consumed on the edge where it is high
- flush  in  1  single-cycle request to emit the current partial word
- m_data  out  DWIDTH*NWORDS  packed word; word i at bits [i*DWIDTH +: DWIDTH]
- m_keep  out  NWORDS  bit i=1 -> word i valid; always contiguous from bit 0
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- busy  out  1  accumulator non-empty, or m_valid high

Behaviour:
- Reset (rst=1 at an edge) clears everything, including mid-packet:
  - m_valid=0, m_data=0, m_keep=0, busy=0.
  - Accumulator count=0, idle counter=0, pending-emit=0.
  - Partial data is discarded.
  - fifo_read is forced 0 while rst=1.
- Slot free: slot_free = !m_valid || m_ready.
- Emit pending: set when count=NWORDS, on flush, or on timeout, and the output slot was busy at that edge. While set, no further reads occur.
- Read strobe (combinational): fifo_read = !rst && !fifo_empty && !pending.
- Capture: on a read edge, fifo_data is stored into accumulator slot [count] and count increments. Word order is little-endian (first popped word occupies the LSBs).
- Emit trigger, evaluated using the post-read count:
  - count reaches NWORDS; or
  - flush=1 and count>0; or
  - idle counter = TIMEOUT-1 with count>0 and no read this cycle.
- Emit action:
  - If slot_free: output register <= accumulator; m_keep <= (1<<count)-1; m_valid=1 next cycle; count<=0; idle<=0; pending<=0.
  - Otherwise: pending<=1. The emit repeats on the first later cycle where slot_free=1.
- Latency: the last word is popped at edge t, and m_valid=1 and m_data appear after edge t. This gives one cycle from pop to output when the slot is free.
- Output hold: m_data, m_keep and m_valid stay stable while m_valid=1 and m_ready=0. On m_valid&&m_ready with no new emit, m_valid drops next cycle.
- Back-to-back: an emit in the same cycle as a handshake is legal, so full throughput is one packed word per NWORDS cycles.
- Idle counter:
  - Cleared on a read and whenever count=0.
  - Otherwise increments and saturates at TIMEOUT-1.
- Flush:
  - With count=0: ignored, not remembered.
  - With count>0 and slot busy: sets pending.
  - Same cycle as a read: the word read that cycle is included.
  - During pending: has no additional effect.
- Unused output slots: for a partial emit, m_data words beyond count are driven 0.
- Illegal use: fifo_read is never asserted while fifo_empty=1. No read is lost or duplicated under any m_ready pattern.

Test Plan:
- Ideal stream:
  - Stimulus: FIFO preloaded with 0x01..0x08, m_ready=1.
  - Response: m_data=0x04030201 with m_keep=4'b1111, then 0x08070605 with m_keep=4'b1111.
  - Exactly 8 fifo_read pulses.
- Timeout partial:
  - Stimulus: push 0xA1, 0xA2, then the FIFO stays empty.
  - Response: exactly 16 idle cycles after the 0xA2 pop, m_data=0x0000A2A1 and m_keep=4'b0011.
- Backpressure:
  - Stimulus: 12 words queued, m_ready=0 for 20 cycles.
  - Response: the first packed word is held stable; the accumulator fills (reads stop at 8 popped); there are no further reads.
  - After m_ready=1: three words in order, 12 pops total.
- Flush:
  - Stimulus: flush asserted on the same cycle as the 3rd pop (0x11, 0x22, 0x33).
  - Response: next cycle m_data=0x00332211, m_keep=4'b0111.
  - A flush with count=0 produces no output.
- Flush while blocked:
  - Stimulus: m_valid held with m_ready=0, then flush with count=2.
  - Response: fifo_read stays 0 until m_ready=1; then the partial word is emitted with m_keep=4'b0011.
- Reset mid-packet:
  - Stimulus: rst after 2 pops.
  - Response: the next 4 pops form a fresh word with m_keep=4'b1111; the old words are absent.
